// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: 16-bit add performed one nibble per cycle through an
// external combinational 4-bit adder (add_a/add_b/add_c_in -> add_sum/add_c_out).
// Start is accepted in IDLE, four RUN cycles walk nibbles 0..3, DONE pulses once.
// Optional build macro: NIBBLE_SERIAL_ADDER_OVF_EN adds the two's-complement ovf output.
//
// state | meaning
// IDLE  | waiting for start; adder inputs forced to 0
// RUN   | one nibble per edge, idx selects the nibble
// DONE  | one-cycle done pulse, result valid, then back to IDLE

module nibble_serial_adder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   input  logic        c_in,
   output logic [3:0]  add_a,
   output logic [3:0]  add_b,
   output logic        add_c_in,
   input  logic [3:0]  add_sum,
   input  logic        add_c_out,
   output logic        busy,
   output logic        done,
   output logic [15:0] sum,
   output logic        c_out
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   ,
   output logic        ovf
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  idx;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic        carry;
   logic        accept;

   assign accept = (state == IDLE) && start;

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status/adder-input decode.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      add_a     = 4'd0;
      add_b     = 4'd0;
      add_c_in  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy     = 1'b1;
            add_a    = a_q[{idx, 2'b00} +: 4];
            add_b    = b_q[{idx, 2'b00} +: 4];
            add_c_in = carry;
            if (idx == 2'd3) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture, per-nibble result write-back and carry chaining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= 16'd0;
         b_q   <= 16'd0;
         idx   <= 2'd0;
         carry <= 1'b0;
         sum   <= 16'd0;
         c_out <= 1'b0;
      end else if (accept) begin
         a_q   <= op_a;
         b_q   <= op_b;
         idx   <= 2'd0;
         carry <= c_in;
         sum   <= 16'd0;
         c_out <= 1'b0;
      end else if (state == RUN) begin
         sum[{idx, 2'b00} +: 4] <= add_sum;
         carry                  <= add_c_out;
         idx                    <= idx + 2'd1;
         if (idx == 2'd3) begin
            c_out <= add_c_out;
         end
      end
   end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   // Signed overflow: like-signed operands producing a result of the other sign.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (accept) begin
         ovf <= 1'b0;
      end else if ((state == RUN) && (idx == 2'd3)) begin
         ovf <= (a_q[15] == b_q[15]) && (add_sum[3] != a_q[15]);
      end
   end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_nibble_serial_adder;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        c_in;
   logic [3:0]  add_a;
   logic [3:0]  add_b;
   logic        add_c_in;
   logic [3:0]  add_sum;
   logic        add_c_out;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        c_out;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic        ovf;
`endif

   typedef struct {
      logic [15:0] sum;
      logic        c;
      logic        ovf;
      int          acc_cyc;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   nibble_serial_adder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
      .c_in      (c_in),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_c_in  (add_c_in),
      .add_sum   (add_sum),
      .add_c_out (add_c_out),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .c_out     (c_out)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // External 4-bit adder.
   logic [4:0] add_res;
   assign add_res   = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_c_in};
   assign add_sum   = add_res[3:0];
   assign add_c_out = add_res[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sum", {16'd0, sum}, {16'd0, e.sum});
            chk("c_out", {31'd0, c_out}, {31'd0, e.c});
            chk("latency", cyc - e.acc_cyc, 32'd4);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
         end
      end
   end

   task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic [15:0] es, input logic ec, input logic eo,
                         input logic [3:0] eseq, input bit disturb);
      exp_t e;
      logic [3:0] seq;
      int   n_busy;
      bit   got;
      seq    = 4'd0;
      n_busy = 0;
      got    = 0;
      @(negedge clk);
      start = 1'b1;
      op_a  = a;
      op_b  = b;
      c_in  = ci;
      @(posedge clk);
      #1;
      e.sum     = es;
      e.c       = ec;
      e.ovf     = eo;
      e.acc_cyc = cyc;
      q.push_back(e);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start = 1'b0;
            chk("sum_cleared", {15'd0, c_out, sum}, 32'd0);
         end
         if (disturb && k == 1) begin
            start = 1'b1;
            op_a  = 16'hFFFF;
            op_b  = 16'hFFFF;
            c_in  = 1'b1;
         end
         if (disturb && k == 2) start = 1'b0;
         if (done) begin
            got = 1;
            if (disturb) start = 1'b1;
            break;
         end
         if (busy) begin
            if (n_busy < 4) seq[n_busy] = add_c_in;
            n_busy++;
         end
      end
      if (!got) chk("done_timeout", 32'd0, 32'd1);
      chk("busy_cycles", n_busy, 32'd4);
      chk("carry_seq", {28'd0, seq}, {28'd0, eseq});
      @(negedge clk);
      start = 1'b0;
      chk("idle_after_done", {31'd0, busy}, 32'd0);
      chk("result_hold", {15'd0, c_out, sum}, {15'd0, ec, es});
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op_a  = 16'd0;
      op_b  = 16'd0;
      c_in  = 1'b0;
      #12;
      chk("reset_outs", {busy, done, c_out, add_c_in, add_a, add_b, sum}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      do_add(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000, 0);
      do_add(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110, 0);
      do_add(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111, 0);
      do_add(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110, 0);
      do_add(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000, 0);
      do_add(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0, 4'b1010, 1);

      // Abort in the second RUN cycle; the monitor flags any done that follows.
      @(negedge clk);
      start = 1'b1;
      op_a  = 16'h1111;
      op_b  = 16'h2222;
      c_in  = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("run_before_abort", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_outs", {busy, done, c_out, add_c_in, add_a, add_b, sum}, 32'd0);
      repeat (2) @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;

      do_add(16'h00AA, 16'h0055, 1'b0, 16'h00FF, 1'b0, 1'b0, 4'b0000, 0);

      repeat (6) @(negedge clk);
      chk("queue_empty", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
